// File: rtl/csr_wr_sched.sv
// Scheduler for the single CSR-file write port: in-order queue of retire-released writes
// plus the three-write trap sequence (mepc, mcause, mtval), with pending/RaW query.
module csr_wr_sched #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 8,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq_valid,
  output logic            enq_ready,
  input  logic [ID_W-1:0] enq_id,
  input  logic [11:0]     enq_addr,
  input  logic [XLEN-1:0] enq_data,
  input  logic            retire_valid,
  input  logic [ID_W-1:0] retire_id,
  input  logic            flush,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_mepc,
  input  logic [XLEN-1:0] trap_mcause,
  input  logic [XLEN-1:0] trap_mtval,
  output logic            trap_ack,
  input  logic [11:0]     query_addr,
  output logic            query_hit,
  output logic            pending,
  output logic            csr_wvalid,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, W_EPC, W_CAUSE, W_TVAL} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [XLEN-1:0]    epc_q, epc_d, cause_q, cause_d, tval_q, tval_d;

  logic [ID_W-1:0]    id_q   [DEPTH];
  logic [11:0]        addr_q [DEPTH];
  logic [XLEN-1:0]    data_q [DEPTH];

  logic busy, pop, enq_fire, trap_start, trap_wr;

  assign busy       = (state_q != IDLE);
  assign pop        = !rst && retire_valid && valid_q[rd_ptr_q] && (id_q[rd_ptr_q] == retire_id);
  assign enq_ready  = rst || ((count_q < CNT_W'(DEPTH)) && !busy && !flush);
  assign enq_fire   = !rst && enq_valid && enq_ready;
  assign trap_start = !rst && !busy && trap_req && (count_q == '0) && !pop;
  // A retiring queue write owns the port; the trap write slips one cycle.
  assign trap_wr    = !rst && busy && !pop;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: payload storage is not reset; valid_q alone decides whether an entry is meaningful.
  always_ff @(posedge clk) begin
    epc_q   <= epc_d;
    cause_q <= cause_d;
    tval_q  <= tval_d;
    if (enq_fire) begin
      id_q[wr_ptr_q]   <= enq_id;
      addr_q[wr_ptr_q] <= enq_addr;
      data_q[wr_ptr_q] <= enq_data;
    end
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;

    unique case (state_q)
      IDLE:    if (trap_start) state_d = W_EPC;
      W_EPC:   if (trap_wr)    state_d = W_CAUSE;
      W_CAUSE: if (trap_wr)    state_d = W_TVAL;
      W_TVAL:  if (trap_wr)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase

    if (trap_start) begin
      epc_d   = trap_mepc;
      cause_d = trap_mcause;
      tval_d  = trap_mtval;
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end

    if (flush) begin
      valid_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(enq_fire) - CNT_W'(pop);
    end
  end

  // Output logic
  always_comb begin
    csr_wvalid = 1'b0;
    csr_waddr  = '0;
    csr_wdata  = '0;
    trap_ack   = 1'b0;
    query_hit  = 1'b0;
    pending    = !rst && ((count_q != '0) || busy);

    if (pop) begin
      csr_wvalid = 1'b1;
      csr_waddr  = addr_q[rd_ptr_q];
      csr_wdata  = data_q[rd_ptr_q];
    end else if (trap_wr) begin
      csr_wvalid = 1'b1;
      unique case (state_q)
        W_EPC:   begin csr_waddr = 12'h341; csr_wdata = epc_q;   end
        W_CAUSE: begin csr_waddr = 12'h342; csr_wdata = cause_q; end
        W_TVAL:  begin csr_waddr = 12'h343; csr_wdata = tval_q; trap_ack = 1'b1; end
        default: begin csr_waddr = '0;      csr_wdata = '0;      end
      endcase
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && valid_q[i] && (addr_q[i] == query_addr)) query_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_csr_wr_sched.sv
// Self-checking bench for csr_wr_sched: directed vector table, hand-written trap/flush
// sequences and a randomized run, all compared against a queue-based reference model.
module tb_csr_wr_sched;

  localparam int DEPTH = 4;
  localparam int ID_W  = 8;
  localparam int XLEN  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            enq_valid;
  logic            enq_ready;
  logic [ID_W-1:0] enq_id;
  logic [11:0]     enq_addr;
  logic [XLEN-1:0] enq_data;
  logic            retire_valid;
  logic [ID_W-1:0] retire_id;
  logic            flush;
  logic            trap_req;
  logic [XLEN-1:0] trap_mepc, trap_mcause, trap_mtval;
  logic            trap_ack;
  logic [11:0]     query_addr;
  logic            query_hit;
  logic            pending;
  logic            csr_wvalid;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;

  csr_wr_sched #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_id(enq_id),
    .enq_addr(enq_addr), .enq_data(enq_data),
    .retire_valid(retire_valid), .retire_id(retire_id), .flush(flush),
    .trap_req(trap_req), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
    .trap_mtval(trap_mtval), .trap_ack(trap_ack),
    .query_addr(query_addr), .query_hit(query_hit), .pending(pending),
    .csr_wvalid(csr_wvalid), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: program-order list of buffered writes plus trap phase (0 = idle,
  // 1..3 = next trap write is mepc/mcause/mtval).
  typedef struct {
    logic [ID_W-1:0] id;
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  int              phase = 0;
  logic [XLEN-1:0] m_epc, m_cause, m_tval;
  logic            last_ack;

  task automatic idle_inputs();
    enq_valid    = 1'b0; enq_id = '0; enq_addr = '0; enq_data = '0;
    retire_valid = 1'b0; retire_id = '0; flush = 1'b0;
    trap_req     = 1'b0; query_addr = '0;
  endtask

  // Settle mid-cycle, compare against the model, then advance the model past the coming edge.
  task automatic eval();
    logic            pop, start, e_ready, e_w, e_ack, e_pend, e_hit;
    logic [11:0]     e_a;
    logic [XLEN-1:0] e_d;
    #3;
    pop = 1'b0; start = 1'b0;
    e_ready = 1'b1; e_w = 1'b0; e_ack = 1'b0; e_pend = 1'b0; e_hit = 1'b0;
    e_a = '0; e_d = '0;
    if (!rst) begin
      pop     = retire_valid && (mq.size() > 0) && (mq[0].id == retire_id);
      e_ready = (mq.size() < DEPTH) && (phase == 0) && !flush;
      if (pop) begin
        e_w = 1'b1; e_a = mq[0].addr; e_d = mq[0].data;
      end else if (phase != 0) begin
        e_w   = 1'b1;
        e_a   = 12'(12'h340 + phase);
        e_d   = (phase == 1) ? m_epc : (phase == 2) ? m_cause : m_tval;
        e_ack = (phase == 3);
      end
      foreach (mq[i]) if (mq[i].addr == query_addr) e_hit = 1'b1;
      e_pend = (mq.size() != 0) || (phase != 0);
    end
    check("m_enq_ready", 64'(enq_ready), 64'(e_ready));
    check("m_wvalid",    64'(csr_wvalid), 64'(e_w));
    check("m_waddr",     64'(csr_waddr), 64'(e_a));
    check("m_wdata",     csr_wdata, e_d);
    check("m_trap_ack",  64'(trap_ack), 64'(e_ack));
    check("m_pending",   64'(pending), 64'(e_pend));
    check("m_query_hit", 64'(query_hit), 64'(e_hit));
    last_ack = e_ack;

    if (rst) begin
      mq.delete();
      phase = 0;
    end else begin
      start = (phase == 0) && trap_req && (mq.size() == 0) && !pop;
      if (pop) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (enq_valid && e_ready) mq.push_back('{enq_id, enq_addr, enq_data});
      if (start) begin
        phase = 1; m_epc = trap_mepc; m_cause = trap_mcause; m_tval = trap_mtval;
      end else if (phase != 0 && !pop) begin
        phase = (phase == 3) ? 0 : phase + 1;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            ev;
    logic [ID_W-1:0] eid;
    logic [11:0]     ea;
    logic [XLEN-1:0] ed;
    logic            rv;
    logic [ID_W-1:0] rid;
    logic            fl;
    logic [11:0]     qa;
    logic            x_ready;
    logic            x_w;
    logic [11:0]     x_a;
    logic [XLEN-1:0] x_d;
    logic            x_pend;
    logic            x_hit;
  } vec_t;

  function automatic vec_t mk(input logic ev, input logic [ID_W-1:0] eid, input logic [11:0] ea,
                              input logic [XLEN-1:0] ed, input logic rv, input logic [ID_W-1:0] rid,
                              input logic fl, input logic [11:0] qa, input logic x_ready,
                              input logic x_w, input logic [11:0] x_a, input logic [XLEN-1:0] x_d,
                              input logic x_pend, input logic x_hit);
    vec_t v;
    v = '{ev, eid, ea, ed, rv, rid, fl, qa, x_ready, x_w, x_a, x_d, x_pend, x_hit};
    return v;
  endfunction

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 12'h300;
      1:       return 12'h301;
      2:       return 12'h305;
      default: return 12'h341;
    endcase
  endfunction

  vec_t            tbl[13];
  logic [XLEN-1:0] t5_exp[3];
  logic            drop_trap;

  initial begin
    // Single write released by retire; full queue with wrap; non-head retire and flush.
    tbl[0]  = mk(1, 5, 12'h300, 64'h8, 0, 0, 0, 12'h300, 1, 0, 12'h000, 64'h0, 0, 0);
    tbl[1]  = mk(0, 0, 12'h000, 64'h0, 0, 0, 0, 12'h300, 1, 0, 12'h000, 64'h0, 1, 1);
    tbl[2]  = mk(0, 0, 12'h000, 64'h0, 1, 5, 0, 12'h300, 1, 1, 12'h300, 64'h8, 1, 1);
    tbl[3]  = mk(0, 0, 12'h000, 64'h0, 0, 0, 0, 12'h300, 1, 0, 12'h000, 64'h0, 0, 0);
    tbl[4]  = mk(1, 1, 12'h301, 64'h1, 0, 0, 0, 12'h304, 1, 0, 12'h000, 64'h0, 0, 0);
    tbl[5]  = mk(1, 2, 12'h302, 64'h2, 0, 0, 0, 12'h304, 1, 0, 12'h000, 64'h0, 1, 0);
    tbl[6]  = mk(1, 3, 12'h303, 64'h3, 0, 0, 0, 12'h304, 1, 0, 12'h000, 64'h0, 1, 0);
    tbl[7]  = mk(1, 4, 12'h304, 64'h4, 0, 0, 0, 12'h304, 1, 0, 12'h000, 64'h0, 1, 0);
    tbl[8]  = mk(1, 9, 12'h309, 64'h9, 1, 1, 0, 12'h304, 0, 1, 12'h301, 64'h1, 1, 1);
    tbl[9]  = mk(1, 9, 12'h309, 64'h9, 0, 0, 0, 12'h309, 1, 0, 12'h000, 64'h0, 1, 0);
    tbl[10] = mk(0, 0, 12'h000, 64'h0, 1, 3, 0, 12'h309, 0, 0, 12'h000, 64'h0, 1, 1);
    tbl[11] = mk(0, 0, 12'h000, 64'h0, 0, 0, 1, 12'h303, 0, 0, 12'h000, 64'h0, 1, 1);
    tbl[12] = mk(0, 0, 12'h000, 64'h0, 1, 2, 0, 12'h303, 1, 0, 12'h000, 64'h0, 0, 0);

    idle_inputs();
    trap_mepc = '0; trap_mcause = '0; trap_mtval = '0;
    rst = 1'b1;
    eval(); adv();
    eval(); adv();
    rst = 1'b0;
    eval();
    check("reset_pending", 64'(pending), 64'h0);
    check("reset_ready",   64'(enq_ready), 64'h1);
    adv();

    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      enq_valid = tbl[i].ev; enq_id = tbl[i].eid; enq_addr = tbl[i].ea; enq_data = tbl[i].ed;
      retire_valid = tbl[i].rv; retire_id = tbl[i].rid; flush = tbl[i].fl;
      query_addr = tbl[i].qa;
      eval();
      check($sformatf("tbl%0d_ready", i), 64'(enq_ready), 64'(tbl[i].x_ready));
      check($sformatf("tbl%0d_wvalid", i), 64'(csr_wvalid), 64'(tbl[i].x_w));
      check($sformatf("tbl%0d_waddr", i), 64'(csr_waddr), 64'(tbl[i].x_a));
      check($sformatf("tbl%0d_wdata", i), csr_wdata, tbl[i].x_d);
      check($sformatf("tbl%0d_pending", i), 64'(pending), 64'(tbl[i].x_pend));
      check($sformatf("tbl%0d_hit", i), 64'(query_hit), 64'(tbl[i].x_hit));
      adv();
    end

    // Flush in the same cycle as a head retire: head written, the rest dropped.
    idle_inputs(); enq_valid = 1; enq_id = 1; enq_addr = 12'h310; enq_data = 64'ha;
    eval(); adv();
    enq_id = 2; enq_addr = 12'h311; enq_data = 64'hb;
    eval(); adv();
    idle_inputs(); flush = 1; retire_valid = 1; retire_id = 1;
    eval();
    check("t4_pop_wvalid", 64'(csr_wvalid), 64'h1);
    check("t4_pop_waddr",  64'(csr_waddr), 64'h310);
    adv();
    idle_inputs(); retire_valid = 1; retire_id = 2; query_addr = 12'h311;
    eval();
    check("t4_dropped_wvalid", 64'(csr_wvalid), 64'h0);
    check("t4_dropped_hit",    64'(query_hit), 64'h0);
    check("t4_pending",        64'(pending), 64'h0);
    adv();

    // Trap on empty queue: three back-to-back writes, ack with the third.
    t5_exp[0] = 64'h1000; t5_exp[1] = 64'h2; t5_exp[2] = 64'hdead;
    idle_inputs(); trap_req = 1;
    trap_mepc = 64'h1000; trap_mcause = 64'h2; trap_mtval = 64'hdead;
    eval();
    check("t5_accept_wvalid", 64'(csr_wvalid), 64'h0);
    adv();
    for (int k = 0; k < 3; k++) begin
      eval();
      check($sformatf("t5_w%0d_wvalid", k), 64'(csr_wvalid), 64'h1);
      check($sformatf("t5_w%0d_waddr", k), 64'(csr_waddr), 64'(12'h341 + k));
      check($sformatf("t5_w%0d_wdata", k), csr_wdata, t5_exp[k]);
      check($sformatf("t5_w%0d_ack", k), 64'(trap_ack), (k == 2) ? 64'h1 : 64'h0);
      adv();
    end
    trap_req = 0;
    eval();
    check("t5_done_pending", 64'(pending), 64'h0);
    adv();

    // Trap behind a queued write, then reset mid-sequence.
    idle_inputs(); enq_valid = 1; enq_id = 3; enq_addr = 12'h320; enq_data = 64'h33;
    eval(); adv();
    idle_inputs(); trap_req = 1; retire_valid = 1; retire_id = 3;
    trap_mepc = 64'h2000; trap_mcause = 64'hb; trap_mtval = 64'h0;
    eval();
    check("t6_queue_first", 64'(csr_waddr), 64'h320);
    adv();
    retire_valid = 0;
    eval();
    check("t6_accept_wvalid", 64'(csr_wvalid), 64'h0);
    adv();
    eval();
    check("t6_epc_waddr", 64'(csr_waddr), 64'h341);
    check("t6_epc_wdata", csr_wdata, 64'h2000);
    adv();
    rst = 1;
    eval();
    check("t6_rst_wvalid", 64'(csr_wvalid), 64'h0);
    check("t6_rst_ack",    64'(trap_ack), 64'h0);
    adv();
    rst = 0; trap_req = 0;
    for (int k = 0; k < 4; k++) begin
      eval();
      check($sformatf("t6_after_rst%0d_wvalid", k), 64'(csr_wvalid), 64'h0);
      check($sformatf("t6_after_rst%0d_pending", k), 64'(pending), 64'h0);
      adv();
    end

    // Randomized traffic against the model.
    idle_inputs();
    drop_trap = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (drop_trap || rst) trap_req = 1'b0;
      drop_trap    = 1'b0;
      enq_valid    = 1'($urandom_range(0, 1));
      enq_id       = ID_W'($urandom_range(0, 7));
      enq_addr     = pick_addr();
      enq_data     = {$urandom, $urandom};
      retire_valid = ($urandom_range(0, 2) != 0);
      retire_id    = (mq.size() > 0 && $urandom_range(0, 2) != 0) ? mq[0].id
                                                                    : ID_W'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 24) == 0);
      query_addr   = pick_addr();
      if (!trap_req && !rst && $urandom_range(0, 19) == 0) begin
        trap_req    = 1'b1;
        trap_mepc   = {$urandom, $urandom};
        trap_mcause = {$urandom, $urandom};
        trap_mtval  = {$urandom, $urandom};
      end
      eval();
      if (last_ack) drop_trap = 1'b1;
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
